// File: rtl/branch_predict_unit_if.sv
// rtl/branch_predict_unit_if.sv - fetch lookup, EX resolve, redirect and perf signals of the branch predict unit
interface branch_predict_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  f_pc;
    logic             f_pred_taken;
    logic [XLEN-1:0]  f_pred_target;
    logic             ex_valid;
    logic             ex_branch;
    logic             ex_jump;
    logic [6:0]       ex_opcode;
    logic [2:0]       ex_funct3;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_pc_plus4;
    logic [XLEN-1:0]  ex_imm;
    logic [XLEN-1:0]  ex_srca;
    logic [XLEN-1:0]  ex_srcb;
    logic             ex_pred_taken;
    logic [XLEN-1:0]  ex_pred_target;
    logic             ex_taken;
    logic [XLEN-1:0]  ex_next_pc;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] perf_ctl;
    logic [CNT_W-1:0] perf_mispred;

    modport master (
        output f_pc, ex_valid, ex_branch, ex_jump, ex_opcode, ex_funct3, ex_pc,
               ex_pc_plus4, ex_imm, ex_srca, ex_srcb, ex_pred_taken, ex_pred_target,
        input  f_pred_taken, f_pred_target, ex_taken, ex_next_pc, redirect,
               redirect_pc, perf_ctl, perf_mispred
    );

    modport slave (
        input  f_pc, ex_valid, ex_branch, ex_jump, ex_opcode, ex_funct3, ex_pc,
               ex_pc_plus4, ex_imm, ex_srca, ex_srcb, ex_pred_taken, ex_pred_target,
        output f_pred_taken, f_pred_target, ex_taken, ex_next_pc, redirect,
               redirect_pc, perf_ctl, perf_mispred
    );
endinterface

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - direct-mapped BTB with 2-bit bimodal counters, EX branch resolution and redirect
module branch_predict_unit #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_predict_unit_if.slave bus
);
    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    logic            validQ  [ENTRIES];
    logic [TAGW-1:0] tagQ    [ENTRIES];
    logic [XLEN-1:0] targetQ [ENTRIES];
    logic            isJumpQ [ENTRIES];
    logic [1:0]      ctrQ    [ENTRIES];

    logic             redirectQ;
    logic [XLEN-1:0]  redirectPcQ;
    logic [CNT_W-1:0] perfCtlQ;
    logic [CNT_W-1:0] perfMispredQ;

    logic [IDX-1:0]  fIdx, exIdx;
    logic [TAGW-1:0] fTag, exTag;
    logic            fHit, exHit, fTaken;
    logic            cond, exTaken, isJalr, act, mispred, train, clearAlias;
    logic [XLEN-1:0] exTarget, nextPc;
    logic [1:0]      ctrNext;

    // Lookup reads registered tables only, so a same-cycle write is not visible yet.
    assign fIdx   = bus.f_pc[IDX+1:2];
    assign fTag   = bus.f_pc[XLEN-1:IDX+2];
    assign fHit   = validQ[fIdx] && (tagQ[fIdx] == fTag);
    assign fTaken = fHit && (isJumpQ[fIdx] || ctrQ[fIdx][1]);

    assign bus.f_pred_taken  = fTaken;
    assign bus.f_pred_target = fTaken ? targetQ[fIdx] : bus.f_pc + XLEN'(4);

    always_comb begin
        cond = 1'b0;
        case (bus.ex_funct3)
            3'b000:  cond = (bus.ex_srca == bus.ex_srcb);
            3'b001:  cond = (bus.ex_srca != bus.ex_srcb);
            3'b100:  cond = ($signed(bus.ex_srca) <  $signed(bus.ex_srcb));
            3'b101:  cond = ($signed(bus.ex_srca) >= $signed(bus.ex_srcb));
            3'b110:  cond = (bus.ex_srca <  bus.ex_srcb);
            3'b111:  cond = (bus.ex_srca >= bus.ex_srcb);
            default: cond = 1'b0;
        endcase
    end

    assign isJalr   = bus.ex_jump && (bus.ex_opcode == 7'b1100111);
    assign exTarget = isJalr ? ((bus.ex_srca + bus.ex_imm) & ~XLEN'(1))
                             : (bus.ex_pc + bus.ex_imm);
    assign exTaken  = bus.ex_jump || (bus.ex_branch && cond);
    assign nextPc   = exTaken ? exTarget : bus.ex_pc_plus4;

    assign bus.ex_taken   = exTaken;
    assign bus.ex_next_pc = nextPc;

    // The slot right after a redirect is wrong-path and must not train or redirect again.
    assign act        = bus.ex_valid && !redirectQ;
    assign mispred    = act && ((bus.ex_pred_taken != exTaken) ||
                                (exTaken && (bus.ex_pred_target != nextPc)));
    assign train      = act && (bus.ex_branch || bus.ex_jump);
    assign clearAlias = act && !(bus.ex_branch || bus.ex_jump) && bus.ex_pred_taken;

    assign exIdx = bus.ex_pc[IDX+1:2];
    assign exTag = bus.ex_pc[XLEN-1:IDX+2];
    assign exHit = validQ[exIdx] && (tagQ[exIdx] == exTag);

    always_comb begin
        ctrNext = ctrQ[exIdx];
        if (!exHit)
            ctrNext = exTaken ? 2'b10 : 2'b01;
        else if (exTaken)
            ctrNext = (ctrQ[exIdx] == 2'b11) ? 2'b11 : ctrQ[exIdx] + 2'd1;
        else
            ctrNext = (ctrQ[exIdx] == 2'b00) ? 2'b00 : ctrQ[exIdx] - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                validQ[i]  <= 1'b0;
                tagQ[i]    <= '0;
                targetQ[i] <= '0;
                isJumpQ[i] <= 1'b0;
                ctrQ[i]    <= 2'b01;
            end
            redirectQ    <= 1'b0;
            redirectPcQ  <= '0;
            perfCtlQ     <= '0;
            perfMispredQ <= '0;
        end else begin
            redirectQ <= mispred;
            if (mispred)
                redirectPcQ <= nextPc;
            if (train) begin
                validQ[exIdx]  <= 1'b1;
                tagQ[exIdx]    <= exTag;
                targetQ[exIdx] <= exTarget;
                isJumpQ[exIdx] <= bus.ex_jump;
                ctrQ[exIdx]    <= ctrNext;
            end else if (clearAlias) begin
                validQ[exIdx] <= 1'b0;
            end
            if (train && (perfCtlQ != '1))
                perfCtlQ <= perfCtlQ + CNT_W'(1);
            if (mispred && (perfMispredQ != '1))
                perfMispredQ <= perfMispredQ + CNT_W'(1);
        end
    end

    assign bus.redirect     = redirectQ;
    assign bus.redirect_pc  = redirectPcQ;
    assign bus.perf_ctl     = perfCtlQ;
    assign bus.perf_mispred = perfMispredQ;
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - scoreboard bench for branch_predict_unit with directed vectors
module tb_branch_predict_unit;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] redirQ[$];

    branch_predict_unit_if #(.XLEN(32), .CNT_W(32)) bus ();

    branch_predict_unit #(.XLEN(32), .ENTRIES(16), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every cycle redirect is high must match the oldest expected redirect.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.redirect === 1'b1) begin
                total++;
                if (redirQ.size() == 0) begin
                    bad++;
                    $display("FAIL redirect_unexpected: got redirect_pc 0x%08h expected no redirect", bus.redirect_pc);
                end else begin
                    logic [31:0] e;
                    e = redirQ.pop_front();
                    if (bus.redirect_pc !== e) begin
                        bad++;
                        $display("FAIL redirect_pc: got 0x%08h expected 0x%08h", bus.redirect_pc, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic lookup(input string name, input logic [31:0] pc, input logic expT, input logic [31:0] expTgt);
        bus.f_pc = pc;
        #1;
        chk({name, "_taken"}, {31'd0, bus.f_pred_taken}, {31'd0, expT});
        chk({name, "_target"}, bus.f_pred_target, expTgt);
    endtask

    task automatic drive(input logic br, input logic jp, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] a,
                         input logic [31:0] b, input logic pt, input logic [31:0] ptg);
        bus.ex_valid       = 1'b1;
        bus.ex_branch      = br;
        bus.ex_jump        = jp;
        bus.ex_opcode      = op;
        bus.ex_funct3      = f3;
        bus.ex_pc          = pc;
        bus.ex_pc_plus4    = pc + 32'd4;
        bus.ex_imm         = imm;
        bus.ex_srca        = a;
        bus.ex_srcb        = b;
        bus.ex_pred_taken  = pt;
        bus.ex_pred_target = ptg;
    endtask

    // Called at posedge+1; one EX cycle then one idle cycle so the redirect slot is never consumed.
    task automatic exec(input string name, input logic br, input logic jp, input logic [6:0] op,
                        input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] a, input logic [31:0] b, input logic pt,
                        input logic [31:0] ptg, input logic expT, input logic [31:0] expN,
                        input logic expRedir);
        drive(br, jp, op, f3, pc, imm, a, b, pt, ptg);
        #2;
        chk({name, "_ex_taken"}, {31'd0, bus.ex_taken}, {31'd0, expT});
        chk({name, "_ex_next_pc"}, bus.ex_next_pc, expN);
        if (expRedir) redirQ.push_back(expN);
        @(posedge clk); #1;
        bus.ex_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, OP_ALU, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        bus.ex_valid = 1'b0;
        bus.f_pc     = 32'h100;

        // Reset state
        #2;
        lookup("reset_lookup", 32'h100, 1'b0, 32'h104);
        chk("reset_redirect", {31'd0, bus.redirect}, 32'd0);
        chk("reset_perf_ctl", bus.perf_ctl, 32'd0);
        chk("reset_perf_mispred", bus.perf_mispred, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // BEQ first seen taken -> mispredict, entry trained with ctr=10
        exec("beq1", 1'b1, 1'b0, OP_BR, 3'b000, 32'h100, 32'h40, 32'd5, 32'd5, 1'b0, 32'h104,
             1'b1, 32'h140, 1'b1);
        lookup("beq1_lookup", 32'h100, 1'b1, 32'h140);
        chk("beq1_perf_mispred", bus.perf_mispred, 32'd1);

        // Two more taken (ctr 11, 11), then not-taken twice (10 still taken, 01 not taken)
        exec("beq2", 1'b1, 1'b0, OP_BR, 3'b000, 32'h100, 32'h40, 32'd5, 32'd5, 1'b1, 32'h140,
             1'b1, 32'h140, 1'b0);
        exec("beq3", 1'b1, 1'b0, OP_BR, 3'b000, 32'h100, 32'h40, 32'd5, 32'd5, 1'b1, 32'h140,
             1'b1, 32'h140, 1'b0);
        exec("beq4", 1'b1, 1'b0, OP_BR, 3'b000, 32'h100, 32'h40, 32'd5, 32'd6, 1'b1, 32'h140,
             1'b0, 32'h104, 1'b1);
        lookup("beq4_lookup", 32'h100, 1'b1, 32'h140);
        exec("beq5", 1'b1, 1'b0, OP_BR, 3'b000, 32'h100, 32'h40, 32'd5, 32'd6, 1'b1, 32'h140,
             1'b0, 32'h104, 1'b1);
        lookup("beq5_lookup", 32'h100, 1'b0, 32'h104);
        chk("beq_perf_ctl", bus.perf_ctl, 32'd5);
        chk("beq_perf_mispred", bus.perf_mispred, 32'd3);

        // JALR target LSB cleared; jump entry predicts taken
        exec("jalr", 1'b0, 1'b1, OP_JALR, 3'b000, 32'h208, 32'd2, 32'h2001, 32'h0, 1'b0, 32'h20C,
             1'b1, 32'h2002, 1'b1);
        lookup("jalr_lookup", 32'h208, 1'b1, 32'h2002);
        chk("jalr_perf_ctl", bus.perf_ctl, 32'd6);
        chk("jalr_perf_mispred", bus.perf_mispred, 32'd4);

        // Back-to-back mispredicts: the second lands in the redirect slot and is ignored
        drive(1'b1, 1'b0, OP_BR, 3'b001, 32'h30C, 32'h10, 32'd1, 32'd2, 1'b0, 32'h310);
        redirQ.push_back(32'h31C);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, OP_BR, 3'b000, 32'h310, 32'h10, 32'd3, 32'd3, 1'b0, 32'h314);
        @(posedge clk); #1;
        bus.ex_valid = 1'b0;
        chk("wrongpath_no_redirect", {31'd0, bus.redirect}, 32'd0);
        chk("wrongpath_perf_ctl", bus.perf_ctl, 32'd7);
        chk("wrongpath_perf_mispred", bus.perf_mispred, 32'd5);
        lookup("wrongpath_lookup", 32'h310, 1'b0, 32'h314);
        @(posedge clk); #1;

        // Reset while a redirect is pending drops it and clears state
        drive(1'b1, 1'b0, OP_BR, 3'b000, 32'h100, 32'h40, 32'd5, 32'd5, 1'b0, 32'h104);
        @(posedge clk); #1;
        bus.ex_valid = 1'b0;
        chk("pending_redirect", {31'd0, bus.redirect}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_drops_redirect", {31'd0, bus.redirect}, 32'd0);
        chk("rst2_perf_ctl", bus.perf_ctl, 32'd0);
        chk("rst2_perf_mispred", bus.perf_mispred, 32'd0);
        lookup("rst2_lookup", 32'h208, 1'b0, 32'h20C);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Signed vs unsigned compare, reserved funct3
        exec("blt", 1'b1, 1'b0, OP_BR, 3'b100, 32'h400, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h404,
             1'b1, 32'h3F8, 1'b1);
        exec("bltu", 1'b1, 1'b0, OP_BR, 3'b110, 32'h404, 32'h20, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h408,
             1'b0, 32'h408, 1'b0);
        exec("f3_010", 1'b1, 1'b0, OP_BR, 3'b010, 32'h408, 32'h20, 32'd0, 32'd0, 1'b0, 32'h40C,
             1'b0, 32'h40C, 1'b0);

        // Alias: non-control predicted taken; same-cycle lookup still sees the old entry
        drive(1'b0, 1'b0, OP_ALU, 3'b000, 32'h400, 32'h0, 32'd0, 32'd0, 1'b1, 32'h3F8);
        bus.f_pc = 32'h400;
        #2;
        chk("alias_ex_taken", {31'd0, bus.ex_taken}, 32'd0);
        chk("alias_prewrite_taken", {31'd0, bus.f_pred_taken}, 32'd1);
        chk("alias_prewrite_target", bus.f_pred_target, 32'h3F8);
        redirQ.push_back(32'h404);
        @(posedge clk); #1;
        bus.ex_valid = 1'b0;
        @(posedge clk); #1;
        lookup("alias_cleared", 32'h400, 1'b0, 32'h404);
        chk("final_perf_ctl", bus.perf_ctl, 32'd3);
        chk("final_perf_mispred", bus.perf_mispred, 32'd2);

        repeat (3) @(posedge clk);
        #1;
        chk("redirects_outstanding", redirQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
